divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 9 +
 rtl/divider_div_step.sv | 40 ++++
 rtl/divider.sv | 112 +++++++++++
 tb/tb_divider.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: state encodings and iteration constant shared by the divider blocks.
package divider_pkg;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10
  } div_state_e;
endpackage

// File: rtl/divider_div_step.sv
// divider_div_step: one restoring-division step plus the adderc/mux2 primitives it uses.
module adderc #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout
);
  assign {cout, y} = a + b + {{WIDTH{1'b0}}, cin};
endmodule

module mux2 #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh, diff;
  logic           cout, ok;
  assign sh = {rem, quo[WIDTH-1]};
  // carry out of sh + ~dvs + 1 means no borrow, i.e. the trial difference is non-negative
  adderc #(.WIDTH(WIDTH+1)) u_sub (
    .a(sh), .b(~{1'b0, dvs}), .cin(1'b1), .y(diff), .cout(cout)
  );
  assign ok = cout & ~diff[WIDTH];
  mux2 #(.WIDTH(WIDTH)) u_restore (
    .d0(sh[WIDTH-1:0]), .d1(diff[WIDTH-1:0]), .s(ok), .y(rem_n)
  );
  assign quo_n = {quo[WIDTH-2:0], ok};
endmodule

// File: rtl/divider.sv
// divider: multi-cycle signed/unsigned restoring divider with fixed WIDTH+1 cycle latency.
module divider
  import divider_pkg::*;
#(parameter int WIDTH = DIV_ITERS) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_n, quo_n, abs_a, abs_b;
  logic neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem_q), .quo(quo_q), .dvs(dvs_q), .rem_n(rem_n), .quo_n(quo_n)
  );
  // b == 0 leaves |a| in rem, so the remainder sign fix naturally returns a unmodified
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ITER;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = abs_a;
        dvs_d   = abs_b;
        neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d  = sgn & a[WIDTH-1];
        bz_d    = (b == '0);
        busy_d  = 1'b1;
      end
      ITER: begin
        rem_d   = rem_n;
        quo_d   = quo_n;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : ITER;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = bz_q;
        lo_d    = bz_q ? '1 : neg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider; results predicted at issue, checked on done.
module tb_divider;
  logic        ph1 = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          due;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0, errors = 0, checks = 0;
  logic [31:0] last_lo = '0, last_hi = '0;

  divider #(.WIDTH(32)) dut (
    .ph1(ph1), .reset(reset), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  always #5 ph1 = ~ph1;
  always @(posedge ph1) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y, input int due);
    exp_t e;
    e.due = due;
    e.dbz = (y == 0);
    if (y == 0) begin
      e.lo = '1;
      e.hi = x;
    end else if (!s) begin
      e.lo = x / y;
      e.hi = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hffff_ffff) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      e.lo = $signed(x) / $signed(y);
      e.hi = $signed(x) % $signed(y);
    end
    return e;
  endfunction

  always @(negedge ph1) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 64'(done), 64'(0));
      else begin
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.due));
        check("lo", 64'(lo), 64'(e.lo));
        check("hi", 64'(hi), 64'(e.hi));
        check("dbz", 64'(dbz), 64'(e.dbz));
        check("busy_at_done", 64'(busy), 64'(0));
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    sb.push_back(model(s, x, y, cyc + 34));
    @(negedge ph1);
    start = 1'b0;
    sgn   = 1'($urandom_range(0, 1));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge ph1);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  logic        s_t[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] a_t[8] = '{32'd100, 32'hffff_fff9, 32'h8000_0000, 32'hffff_ffff,
                          32'd5, 32'd9, 32'hffff_fffb, 32'd7};
  logic [31:0] b_t[8] = '{32'd7, 32'd2, 32'hffff_ffff, 32'd1,
                          32'd0, 32'd3, 32'd0, 32'hffff_fffe};

  initial begin
    int n;
    repeat (2) @(negedge ph1);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    reset = 1'b0;
    @(negedge ph1);
    for (int i = 0; i < 8; i++) begin
      issue(s_t[i], a_t[i], b_t[i]);
      repeat (10) @(negedge ph1);
      check("busy_mid", 64'(busy), 64'(1));
      drain();
      repeat (3) @(negedge ph1);
      check("hold_lo", 64'(lo), 64'(last_lo));
      check("hold_hi", 64'(hi), 64'(last_hi));
    end
    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31));
      drain();
    end
    // start while busy is dropped
    issue(1'b0, 32'd50, 32'd5);
    repeat (4) @(negedge ph1);
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge ph1);
    start = 1'b0;
    drain();
    repeat (40) @(negedge ph1);
    // back-to-back: second start lands in the done cycle
    issue(1'b0, 32'd77, 32'd4);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge ph1);
      n++;
    end
    issue(1'b1, 32'hffff_ff9c, 32'd7);
    drain();
    // reset mid-operation aborts with no done; start held with reset is dropped
    issue(1'b0, 32'd50, 32'd5);
    repeat (8) @(negedge ph1);
    reset = 1'b1;
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd2;
    sb.delete();
    @(negedge ph1);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_dbz", 64'(dbz), 64'(0));
    repeat (40) @(negedge ph1);
    check("abort_idle", 64'(busy), 64'(0));
    issue(1'b0, 32'd20, 32'd6);
    drain();
    repeat (2) @(negedge ph1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
